// File: rtl/sepia_frame_ctrl_if.sv
// Frame-buffer memory port bundle for the sepia frame controller: one
// single-outstanding read channel and one back-pressured write channel.
interface sepia_frame_ctrl_if #(
   parameter int ADDR_W = 24
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [23:0]       rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              wr_ready;

   // Controller side drives requests and consumes read data / write ready.
   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_valid, rd_data, wr_ready
   );

   // Memory side answers requests.
   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_valid, rd_data, wr_ready
   );
endinterface

// File: rtl/sepia_frame_ctrl.sv
// Sepia frame controller: walks a frame in raster order with one pixel in
// flight, reads RGB from the source buffer, applies a fixed-point sepia
// matrix with saturation and writes the result to the destination buffer.
module sepia_frame_ctrl #(
   parameter int DIM_W  = 12,
   parameter int ADDR_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [DIM_W-1:0]   width,
   input  logic [DIM_W-1:0]   height,
   input  logic [ADDR_W-1:0]  src_base,
   input  logic [ADDR_W-1:0]  dst_base,
   output logic               busy,
   output logic               done,
   sepia_frame_ctrl_if.master mem
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, WR, FIN} stateT;

   stateT             curState, nextState;

   logic [DIM_W-1:0]  widthReg, heightReg;
   logic [DIM_W-1:0]  xCnt, yCnt;
   logic [ADDR_W-1:0] srcBaseReg, dstBaseReg;
   logic [ADDR_W-1:0] lineOff;     // y*width, grown by width at each line wrap
   logic [ADDR_W-1:0] pixOff;
   logic [7:0]        pixR, pixG, pixB;
   logic [23:0]       wrDataReg;
   logic              abortPend;   // abort seen while a write was still pending
   logic              startOk, emptyFrame, lastCol, lastPix;
   logic [19:0]       sumR, sumG, sumB;
   logic              rdEn, wrEn;

   // Start loses to a simultaneous abort.
   assign startOk    = start && !abort;
   assign emptyFrame = (width == '0) || (height == '0);
   assign lastCol    = (xCnt == widthReg - DIM_W'(1));
   assign lastPix    = lastCol && (yCnt == heightReg - DIM_W'(1));
   assign pixOff     = lineOff + ADDR_W'(xCnt);

   // Q0.10 coefficients; the worst-case sum (1383*255 + 512) fits in 20 bits.
   assign sumR = 20'd402 * 20'(pixR) + 20'd787 * 20'(pixG) + 20'd194 * 20'(pixB) + 20'd512;
   assign sumG = 20'd357 * 20'(pixR) + 20'd702 * 20'(pixG) + 20'd172 * 20'(pixB) + 20'd512;
   assign sumB = 20'd279 * 20'(pixR) + 20'd547 * 20'(pixG) + 20'd134 * 20'(pixB) + 20'd512;

   // Drop the fraction and clamp to 255 instead of wrapping.
   function automatic logic [7:0] satShift(input logic [19:0] sum);
      logic [9:0] q;
      q = sum[19:10];
      return (q > 10'd255) ? 8'hFF : q[7:0];
   endfunction

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) curState <= IDLE;
      else        curState <= nextState;
   end

   // Next-state decode and state-derived control outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned and infers a latch.
      nextState = curState;
      busy      = 1'b0;
      done      = 1'b0;
      rdEn      = 1'b0;
      wrEn      = 1'b0;
      case (curState)
         IDLE: begin
            if (startOk) nextState = emptyFrame ? FIN : RD_REQ;
         end
         RD_REQ: begin
            busy      = 1'b1;
            rdEn      = 1'b1;
            nextState = abort ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            busy = 1'b1;
            if (abort)             nextState = IDLE;
            else if (mem.rd_valid) nextState = CALC;
         end
         CALC: begin
            busy      = 1'b1;
            nextState = abort ? IDLE : WR;
         end
         WR: begin
            busy = 1'b1;
            wrEn = 1'b1;
            if (mem.wr_ready) begin
               if (abort || abortPend) nextState = IDLE;
               else if (lastPix)       nextState = FIN;
               else                    nextState = RD_REQ;
            end
         end
         FIN: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Frame parameters, raster counters, pixel capture and sepia result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         widthReg   <= '0;
         heightReg  <= '0;
         srcBaseReg <= '0;
         dstBaseReg <= '0;
         xCnt       <= '0;
         yCnt       <= '0;
         lineOff    <= '0;
         pixR       <= '0;
         pixG       <= '0;
         pixB       <= '0;
         wrDataReg  <= '0;
         abortPend  <= 1'b0;
      end else begin
         case (curState)
            IDLE: begin
               if (startOk) begin
                  widthReg   <= width;
                  heightReg  <= height;
                  srcBaseReg <= src_base;
                  dstBaseReg <= dst_base;
                  xCnt       <= '0;
                  yCnt       <= '0;
                  lineOff    <= '0;
                  abortPend  <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (mem.rd_valid && !abort) {pixR, pixG, pixB} <= mem.rd_data;
            end
            CALC: begin
               if (!abort) wrDataReg <= {satShift(sumR), satShift(sumG), satShift(sumB)};
            end
            WR: begin
               if (abort) abortPend <= 1'b1;
               if (mem.wr_ready) begin
                  if (lastCol) begin
                     xCnt    <= '0;
                     yCnt    <= yCnt + DIM_W'(1);
                     lineOff <= lineOff + ADDR_W'(widthReg);
                  end else begin
                     xCnt <= xCnt + DIM_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.rd_en   = rdEn;
   assign mem.wr_en   = wrEn;
   assign mem.rd_addr = srcBaseReg + pixOff;
   assign mem.wr_addr = dstBaseReg + pixOff;
   assign mem.wr_data = wrDataReg;

endmodule
